gcd_euclid_engine: RTL and testbench
====================================

# gcd_euclid_engine

Computes the greatest common divisor of two unsigned W-bit operands with Euclid's remainder algorithm. It sits directly downstream of the shift-subtract remainder stage in the GCD test datapath. It launches a remainder computation per step, consumes each remainder result and feeds it back as the next divisor until the divisor reaches zero. It exposes the team's usual start / result / result_ready handshake to its own consumer.

## Interface
- W, default 20: operand and result width in bits.
- clk  in  1: single clock, all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle pulse that loads the operands and begins a computation. Holding it high keeps the block in its load state.
- a  in  W: first operand, sampled while start is high.
- b  in  W: second operand, sampled while start is high.
- result  out  W: GCD of the last completed computation.
- result_ready  out  1: equals (state == ST_READY) & ~start.
- iter_count  out  8: number of remainder steps in the last computation. Present only with GCD_ITER_COUNT_EN.

## Operation
- Algorithm: while y != 0, (x, y) <= (y, x mod y); result <= x.
- Edge cases: gcd(0,0)=0, gcd(a,0)=a, gcd(0,b)=b.
- States, 2-bit encoding:
  - ST_READY=0: idle, result valid.
  - ST_INITS=1: load x<=a, y<=b.
  - ST_LAUNCH=3: pulse rem_start to the remainder core.
  - ST_WAIT=2: wait for the core to finish.
- start high in any state: next state is ST_INITS and x/y are (re)loaded from a/b. An in-flight computation is abandoned and the core is not restarted until ST_LAUNCH.
- ST_INITS: go to ST_READY with result<=a if b==0. Otherwise go to ST_LAUNCH.
- ST_LAUNCH: assert rem_start for exactly one cycle with dividend x and divisor y, then go to ST_WAIT.
- ST_WAIT, when rem_done is high:
  - If rem==0: result<=y, go to ST_READY.
  - Otherwise: x<=y, y<=rem, go to ST_LAUNCH.
- Remainder core (restoring shift-subtract, arbitrary nonzero divisor):
  - Load r<=x and d<={y,(W-1)'b0}, using a (2W-1)-bit d.
  - Iterate exactly W times: if r>=d then r<=r-d; then d<=d>>1.
  - rem is r[W-1:0].
- Arithmetic is unsigned throughout. The core never sees a zero divisor.

## Timing
- Reset values: state=ST_READY, result=0, x=y=0, iter_count=0, rem_start=0. result_ready therefore reads 1 out of reset unless start is high.
- Core latency: rem_done rises W+1 cycles after the rem_start cycle. One Euclid step therefore costs exactly W+2 cycles (launch cycle plus W+1 wait cycles).
- Top-level latency: let the start pulse be cycle 0 and k the number of remainder steps. result_ready rises at cycle 2 + k·(W+2). For b=0, k=0 and result_ready rises at cycle 2.
- result is stable whenever result_ready is high. It changes only on the transition into ST_READY.
- result_ready is low during any cycle in which start is high, including cycles spent in ST_READY.
- Reset asserted mid-computation: immediately returns to reset values and drops rem_start. The core is also reset.

## Configuration
- GCD_ITER_COUNT_EN defined:
  - iter_count is added as a port.
  - It clears to 0 in ST_INITS and increments at each ST_LAUNCH, saturating at 255.
  - It holds its value in ST_READY.
- GCD_ITER_COUNT_EN undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Shared package gcd_pkg holds:
  - the state encodings ST_READY/ST_INITS/ST_LAUNCH/ST_WAIT;
  - the iteration counter width (8) and its saturation value.
- One sub-module, gcd_rem_core, parameterised by W.
  - Ports: clk, rst_n, rem_start, x, y, rem, rem_done.
  - It owns the r/d registers and a W-step bit counter.
- The top level holds only the x/y/result registers, the FSM and the optional counter.

## Test plan
- a=48, b=18: result=6, k=3, result_ready rises at cycle 68; iter_count=3 when enabled.
- a=5, b=17: first step swaps the operands (5 mod 17 = 5); result=1, k=4, ready at cycle 90.
- Boundary operands:
  - a=0, b=0: result=0, ready at cycle 2.
  - a=0, b=7: result=7, k=1, ready at cycle 24.
  - a=9, b=0: result=9, ready at cycle 2.
- a=0xFFFFF, b=0xFFFFE: result=1, k=2. Checks full-width subtraction with no overflow in the (2W-1)-bit d.
- Restart and reset mid-run:
  - Start a=48, b=18, then pulse start with a=12, b=8 at cycle 30. Expected: result=4, with no intermediate result_ready pulse.
  - Separately, assert rst_n=0 at cycle 40. Expected: result=0 and result_ready=1 immediately after the reset edge.
- Hold start high for 5 cycles with a=10, b=4: result_ready stays low throughout. It rises 2+2·22=46 cycles after the last start cycle, with result=2.

Source files
------------

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the Euclid GCD engine and its remainder core:
//   - FSM state encodings (2-bit, Gray-style ordering READY->INITS->LAUNCH->WAIT)
//   - iteration counter width and saturation value
//   - saturating increment helper for the iteration counter
// -----------------------------------------------------------------------------
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,   // idle, result valid
        ST_INITS  = 2'd1,   // operands loaded, check for trivial b == 0
        ST_LAUNCH = 2'd3,   // one-cycle rem_start pulse to the core
        ST_WAIT   = 2'd2    // waiting for rem_done
    } gcd_state_e;

    localparam int               ITER_W   = 8;
    localparam logic [ITER_W-1:0] ITER_MAX = 8'hFF;

    // Increment that sticks at ITER_MAX instead of wrapping.
    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (v == ITER_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gcd_euclid_engine_if.sv
// -----------------------------------------------------------------------------
// gcd_euclid_engine_if
// Handshake bundle between the GCD engine and its consumer.
//   start        : consumer -> engine, load pulse (holding it keeps the load state)
//   a, b         : consumer -> engine, operands sampled while start is high
//   result       : engine -> consumer, GCD of the last completed computation
//   result_ready : engine -> consumer, idle with a valid result and start low
//   iter_count   : engine -> consumer, remainder steps of the last run
//                  (only when GCD_ITER_COUNT_EN is defined)
// Modports: master = consumer side, slave = engine side.
// -----------------------------------------------------------------------------
interface gcd_euclid_engine_if #(
    parameter int W = 20
);
    import gcd_pkg::*;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         result_ready;

`ifdef GCD_ITER_COUNT_EN
    logic [ITER_W-1:0] iter_count;

    modport master (
        output start, a, b,
        input  result, result_ready, iter_count
    );

    modport slave (
        input  start, a, b,
        output result, result_ready, iter_count
    );
`else
    modport master (
        output start, a, b,
        input  result, result_ready
    );

    modport slave (
        input  start, a, b,
        output result, result_ready
    );
`endif

endinterface

// File: rtl/gcd_rem_core.sv
// -----------------------------------------------------------------------------
// gcd_rem_core
// Restoring shift-subtract remainder: rem = x mod y for any nonzero y.
// The divisor is pre-shifted left by W-1 into a (2W-1)-bit register and walked
// back down one bit per cycle, so W trial subtractions cover every quotient bit.
//
// Ports:
//   clk       in  1 : clock
//   rst_n     in  1 : asynchronous active-low reset
//   rem_start in  1 : load x/y and begin (restarts any run in progress)
//   x         in  W : dividend, sampled with rem_start
//   y         in  W : divisor, sampled with rem_start, never zero
//   rem       out W : remainder, valid while rem_done is high
//   rem_done  out 1 : one-cycle pulse, W+1 cycles after the rem_start cycle
// -----------------------------------------------------------------------------
module gcd_rem_core #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rem_start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] rem,
    output logic         rem_done
);

    localparam int DW = 2 * W - 1;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_reg;
    logic [DW-1:0] d_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [DW-1:0] r_wide;
    logic          r_ge_d;
    logic [W-1:0]  r_step;
    logic          last_step;

    // r is always below 2^W, so when r >= d the divisor also fits in W bits
    // and the subtraction can be done at W bits without losing anything.
    always_comb begin
        r_wide    = {{(W-1){1'b0}}, r_reg};
        r_ge_d    = (r_wide >= d_reg);
        r_step    = r_ge_d ? (r_reg - d_reg[W-1:0]) : r_reg;
        last_step = (cnt_reg == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg    <= '0;
            d_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (rem_start) begin
                r_reg    <= x;
                d_reg    <= {y, {(W-1){1'b0}}};
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                r_reg   <= r_step;
                d_reg   <= d_reg >> 1;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_step) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign rem      = r_reg;
    assign rem_done = done_reg;

endmodule

// File: rtl/gcd_euclid_engine.sv
// -----------------------------------------------------------------------------
// gcd_euclid_engine
// Euclid GCD: while y != 0, (x, y) <= (y, x mod y); result <= x.
// Each remainder step is delegated to gcd_rem_core and costs W+2 cycles.
//
// Ports:
//   clk   in  1 : clock
//   rst_n in  1 : asynchronous active-low reset
//   bus   slave : start/a/b in, result/result_ready (and iter_count) out
//
// Optional feature: define GCD_ITER_COUNT_EN to add the saturating 8-bit
// iter_count output (remainder steps of the last computation).
// -----------------------------------------------------------------------------
module gcd_euclid_engine
    import gcd_pkg::*;
#(
    parameter int W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gcd_euclid_engine_if.slave   bus
);

    gcd_state_e   state_reg, state_next;
    logic [W-1:0] x_reg, x_next;
    logic [W-1:0] y_reg, y_next;
    logic [W-1:0] result_reg, result_next;
`ifdef GCD_ITER_COUNT_EN
    logic [ITER_W-1:0] iter_reg, iter_next;
`endif

    logic         rem_start;
    logic [W-1:0] rem;
    logic         rem_done;

    // A start arriving in the launch cycle abandons the step, so the core
    // is not kicked off for operands that are about to be replaced.
    assign rem_start = (state_reg == ST_LAUNCH) && !bus.start;

    gcd_rem_core #(.W(W)) u_rem_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .rem_start (rem_start),
        .x         (x_reg),
        .y         (y_reg),
        .rem       (rem),
        .rem_done  (rem_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_READY;
            x_reg      <= '0;
            y_reg      <= '0;
            result_reg <= '0;
`ifdef GCD_ITER_COUNT_EN
            iter_reg   <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            result_reg <= result_next;
`ifdef GCD_ITER_COUNT_EN
            iter_reg   <= iter_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        result_next = result_reg;
`ifdef GCD_ITER_COUNT_EN
        iter_next   = iter_reg;
`endif
        if (bus.start) begin
            // Start wins in every state: reload and re-enter the load state.
            state_next = ST_INITS;
            x_next     = bus.a;
            y_next     = bus.b;
        end else begin
            case (state_reg)
                ST_READY: begin
                    state_next = ST_READY;
                end
                ST_INITS: begin
`ifdef GCD_ITER_COUNT_EN
                    iter_next = '0;
`endif
                    // gcd(a, 0) = a covers gcd(0, 0) = 0 as well.
                    if (y_reg == '0) begin
                        result_next = x_reg;
                        state_next  = ST_READY;
                    end else begin
                        state_next  = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
`ifdef GCD_ITER_COUNT_EN
                    iter_next = sat_inc(iter_reg);
`endif
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rem_done) begin
                        if (rem == '0) begin
                            result_next = y_reg;
                            state_next  = ST_READY;
                        end else begin
                            x_next     = y_reg;
                            y_next     = rem;
                            state_next = ST_LAUNCH;
                        end
                    end
                end
                default: begin
                    state_next = ST_READY;
                end
            endcase
        end
    end

    assign bus.result       = result_reg;
    assign bus.result_ready = (state_reg == ST_READY) && !bus.start;
`ifdef GCD_ITER_COUNT_EN
    assign bus.iter_count   = iter_reg;
`endif

endmodule

// File: tb/tb_gcd_euclid_engine.sv
// -----------------------------------------------------------------------------
// tb_gcd_euclid_engine
// Self-checking bench: each transaction pushes its expected GCD, step count
// and ready latency onto a queue; the entry is popped and compared when
// result_ready rises.
// -----------------------------------------------------------------------------
module tb_gcd_euclid_engine;

    localparam int W     = 20;
    localparam int LIMIT = 5000;

    typedef struct {
        logic [W-1:0] res;
        int           k;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    gcd_euclid_engine_if #(.W(W)) bus ();

    gcd_euclid_engine #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference Euclid with step count and ready latency.
    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v);
        exp_t e;
        logic [W-1:0] xm, ym, t;
        xm = a_v;
        ym = b_v;
        e.k = 0;
        while (ym != 0) begin
            t  = xm % ym;
            xm = ym;
            ym = t;
            e.k++;
        end
        e.res = xm;
        e.lat = 2 + e.k * (W + 2);
        return e;
    endfunction

    // Drive one computation with start held for 'hold' cycles, then wait
    // (bounded) for result_ready and score it. Latency is counted from the
    // last cycle in which start was high.
    task automatic run_gcd(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input int hold);
        exp_t e;
        logic saw;
        int   lat;
        exp_q.push_back(model(a_v, b_v));
        bus.a     = a_v;
        bus.b     = b_v;
        bus.start = 1'b1;
        saw       = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.result_ready) saw = 1'b1;
        end
        bus.start = 1'b0;
        lat = 1;
        while (!bus.result_ready && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        $display("txn a=%0d b=%0d result=%0d latency=%0d", a_v, b_v, bus.result, lat);
        check("ready_low_during_start", 32'(saw), 32'd0);
        check("result", 32'(bus.result), 32'(e.res));
        check("latency", 32'(lat), 32'(e.lat));
`ifdef GCD_ITER_COUNT_EN
        check("iter_count", 32'(bus.iter_count), 32'(e.k));
`endif
        @(negedge clk);
        check("result_hold", 32'(bus.result), 32'(e.res));
        check("ready_hold", 32'(bus.result_ready), 32'd1);
    endtask

    initial begin
        logic saw;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_ready", 32'(bus.result_ready), 32'd1);
`ifdef GCD_ITER_COUNT_EN
        check("reset_iter", 32'(bus.iter_count), 32'd0);
`endif
        bus.start = 1'b1;
        #1;
        check("reset_ready_with_start", 32'(bus.result_ready), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the plan.
        run_gcd(20'd48, 20'd18, 1);
        run_gcd(20'd5, 20'd17, 1);
        run_gcd(20'd0, 20'd0, 1);
        run_gcd(20'd0, 20'd7, 1);
        run_gcd(20'd9, 20'd0, 1);
        run_gcd(20'hFFFFF, 20'hFFFFE, 1);

        // Restart at cycle 30: the abandoned run must not flash result_ready.
        bus.a     = 20'd48;
        bus.b     = 20'd18;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        saw = 1'b0;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            if (bus.result_ready) saw = 1'b1;
        end
        check("no_ready_before_restart", 32'(saw), 32'd0);
        run_gcd(20'd12, 20'd8, 1);

        // Reset at cycle 40 of a running computation.
        bus.a     = 20'd48;
        bus.b     = 20'd18;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_result", 32'(bus.result), 32'd0);
        check("midrun_reset_ready", 32'(bus.result_ready), 32'd1);
`ifdef GCD_ITER_COUNT_EN
        check("midrun_reset_iter", 32'(bus.iter_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Start held high for 5 cycles.
        run_gcd(20'd10, 20'd4, 5);

        // A few random operand pairs.
        for (int i = 0; i < 4; i++) begin
            run_gcd(W'($urandom_range(1, 2**W - 1)), W'($urandom_range(1, 2**W - 1)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
